// File: rtl/codec_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : codec_config_sequencer
// Brief    : Boot-time WM8731 register loader. Waits for codec power-up, then
//            issues a fixed table of register writes through the I2C write
//            master's valid/ready port, retrying NACKed writes, and reports
//            done/fail to the audio pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module codec_config_sequencer #(
  parameter logic [6:0] SLAVE_ADDR     = 7'h1A,
  parameter int         NUM_REGS       = 11,
  parameter int         STARTUP_CYCLES = 200,
  parameter int         MAX_RETRIES    = 3,
  parameter int         GAP_CYCLES     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  output logic [6:0] slav_addr_o,
  output logic       read_not_write_o,
  output logic [7:0] reg_addr_o,
  output logic [7:0] write_data_o,
  output logic       write_valid_o,
  input  logic       write_ready_i,
  input  logic       i2c_error_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       fail_o,
  output logic [3:0] reg_index_o
);

  // Shared delay counter covers power-up wait, inter-write gap and the
  // ready-fall watchdog, so it is sized for the largest of the three.
  localparam int c_BW_CYCLES = 4;
  localparam int c_CNT_MAX   = (STARTUP_CYCLES > GAP_CYCLES)
                               ? ((STARTUP_CYCLES > c_BW_CYCLES) ? STARTUP_CYCLES : c_BW_CYCLES)
                               : ((GAP_CYCLES > c_BW_CYCLES) ? GAP_CYCLES : c_BW_CYCLES);
  localparam int c_CNT_W     = $clog2(c_CNT_MAX + 1);
  localparam int c_RTY_W     = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [c_CNT_W-1:0] c_STARTUP_LAST = c_CNT_W'(STARTUP_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST     = c_CNT_W'(GAP_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_BW_LAST      = c_CNT_W'(c_BW_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE      = c_CNT_W'(1);
  localparam logic [c_RTY_W-1:0] c_RTY_MAX      = c_RTY_W'(MAX_RETRIES);
  localparam logic [c_RTY_W-1:0] c_RTY_ONE      = c_RTY_W'(1);
  localparam logic [3:0]         c_LAST_IDX     = 4'(NUM_REGS - 1);

  // Sequencer states
  localparam logic [2:0] ST_WAIT_PWR  = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_BUSY_WAIT = 3'd2;
  localparam logic [2:0] ST_DONE_WAIT = 3'd3;
  localparam logic [2:0] ST_GAP       = 3'd4;
  localparam logic [2:0] ST_FINISH    = 3'd5;
  localparam logic [2:0] ST_FAIL      = 3'd6;

  logic [2:0]         state_q, state_d;
  logic [c_CNT_W-1:0] cnt_q,   cnt_d;
  logic [3:0]         idx_q,   idx_d;
  logic [c_RTY_W-1:0] rty_q,   rty_d;
  logic [15:0]        entry_w;

  // Table entry packed as {reg[6:0], data[8:0]}.
  function automatic logic [15:0] table_entry(input logic [3:0] idx);
    logic [15:0] e;
    case (idx)
      4'd0:    e = {7'd15, 9'h000};  // reset
      4'd1:    e = {7'd0,  9'h017};  // left line in
      4'd2:    e = {7'd1,  9'h017};  // right line in
      4'd3:    e = {7'd2,  9'h079};  // left headphone
      4'd4:    e = {7'd3,  9'h079};  // right headphone
      4'd5:    e = {7'd4,  9'h015};  // mic in, boost, DAC select
      4'd6:    e = {7'd5,  9'h000};  // digital path
      4'd7:    e = {7'd6,  9'h000};  // everything powered
      4'd8:    e = {7'd7,  9'h042};  // master, I2S, 16-bit
      4'd9:    e = {7'd8,  9'h000};  // 48 kHz sampling
      4'd10:   e = {7'd9,  9'h001};  // activate
      default: e = 16'h0000;
    endcase
    return e;
  endfunction

  assign entry_w          = table_entry(idx_q);
  assign slav_addr_o      = SLAVE_ADDR;
  assign read_not_write_o = 1'b0;
  assign reg_addr_o       = {entry_w[15:9], entry_w[8]};
  assign write_data_o     = entry_w[7:0];
  assign reg_index_o      = idx_q;

  // Status decoded straight from the state register so an async reset
  // drops write_valid in the same cycle it is asserted.
  assign write_valid_o = (state_q == ST_ISSUE);
  assign busy_o        = (state_q != ST_FINISH) && (state_q != ST_FAIL);
  assign done_o        = (state_q == ST_FINISH);
  assign fail_o        = (state_q == ST_FAIL);

  // Next-state logic: table walk, handshake tracking and retry accounting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rty_d   = rty_q;
    case (state_q)
      ST_WAIT_PWR: begin
        if (cnt_q == c_STARTUP_LAST) begin
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end else begin
          cnt_d = cnt_q + c_CNT_ONE;
        end
      end
      ST_ISSUE: begin
        // write_valid is held until the master accepts; no withdrawal.
        if (write_ready_i) begin
          cnt_d   = '0;
          state_d = ST_BUSY_WAIT;
        end
      end
      ST_BUSY_WAIT: begin
        if (!write_ready_i) begin
          cnt_d   = '0;
          state_d = ST_DONE_WAIT;
        end else if (cnt_q == c_BW_LAST) begin
          // Master never left idle: the write was lost, retry it.
          cnt_d = '0;
          if (rty_q < c_RTY_MAX) begin
            rty_d   = rty_q + c_RTY_ONE;
            state_d = ST_GAP;
          end else begin
            state_d = ST_FAIL;
          end
        end else begin
          cnt_d = cnt_q + c_CNT_ONE;
        end
      end
      ST_DONE_WAIT: begin
        // The error flag is only meaningful in the first ready cycle.
        if (write_ready_i) begin
          cnt_d = '0;
          if (!i2c_error_i) begin
            rty_d = '0;
            if (idx_q == c_LAST_IDX) begin
              state_d = ST_FINISH;
            end else begin
              idx_d   = idx_q + 4'd1;
              state_d = ST_GAP;
            end
          end else if (rty_q < c_RTY_MAX) begin
            rty_d   = rty_q + c_RTY_ONE;
            state_d = ST_GAP;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_GAP: begin
        if (cnt_q == c_GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end else begin
          cnt_d = cnt_q + c_CNT_ONE;
        end
      end
      ST_FINISH, ST_FAIL: begin
        // Only a terminal state honours start; mid-run pulses are ignored.
        if (start_i) begin
          cnt_d   = '0;
          idx_d   = '0;
          rty_d   = '0;
          state_d = ST_WAIT_PWR;
        end
      end
      default: begin
        cnt_d   = '0;
        idx_d   = '0;
        rty_d   = '0;
        state_d = ST_WAIT_PWR;
      end
    endcase
  end

  // State, counter, index and retry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT_PWR;
      cnt_q   <= '0;
      idx_q   <= '0;
      rty_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rty_q   <= rty_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_codec_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_codec_config_sequencer
// Brief    : Directed self-checking bench with a behavioural I2C write master.
// Revision : 1.0 - initial release
// ============================================================================
module tb_codec_config_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       write_ready = 1'b1;
  logic       i2c_error = 1'b0;
  logic [6:0] slav_addr;
  logic       read_not_write;
  logic [7:0] reg_addr;
  logic [7:0] write_data;
  logic       write_valid;
  logic       busy;
  logic       done;
  logic       fail;
  logic [3:0] reg_index;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] hs_addr[$];
  logic [7:0] hs_data[$];
  logic [3:0] hs_idx[$];
  int         issue_cnt[16];
  int         nack_left[16];
  int         stall = 0;
  int         busy_left = 0;
  bit         hs_pending = 1'b0;
  logic [3:0] cur_idx = 4'd0;

  logic [7:0] exp_addr[11] = '{8'h1E, 8'h00, 8'h02, 8'h04, 8'h06, 8'h08,
                               8'h0A, 8'h0C, 8'h0E, 8'h10, 8'h12};
  logic [7:0] exp_data[11] = '{8'h00, 8'h17, 8'h17, 8'h79, 8'h79, 8'h15,
                               8'h00, 8'h00, 8'h42, 8'h00, 8'h01};

  codec_config_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_i          (start),
    .slav_addr_o      (slav_addr),
    .read_not_write_o (read_not_write),
    .reg_addr_o       (reg_addr),
    .write_data_o     (write_data),
    .write_valid_o    (write_valid),
    .write_ready_i    (write_ready),
    .i2c_error_i      (i2c_error),
    .busy_o           (busy),
    .done_o           (done),
    .fail_o           (fail),
    .reg_index_o      (reg_index)
  );

  always #5 clk = ~clk;

  // Behavioural master: busy 3 cycles after accepting, then ready with the
  // NACK flag valid for exactly one cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      write_ready = 1'b1;
      i2c_error   = 1'b0;
      busy_left   = 0;
      hs_pending  = 1'b0;
    end else begin
      if (hs_pending) begin
        hs_pending  = 1'b0;
        write_ready = 1'b0;
        busy_left   = 3;
      end else if (busy_left > 0) begin
        busy_left = busy_left - 1;
        if (busy_left == 0) begin
          write_ready = 1'b1;
          i2c_error   = (nack_left[cur_idx] > 0);
          if (i2c_error) nack_left[cur_idx] = nack_left[cur_idx] - 1;
        end
      end else begin
        i2c_error = 1'b0;
        if (stall > 0 && write_valid) begin
          write_ready = 1'b0;
          stall = stall - 1;
        end else begin
          write_ready = 1'b1;
        end
      end
      if (write_valid && write_ready) begin
        hs_pending = 1'b1;
        cur_idx    = reg_index;
        hs_addr.push_back(reg_addr);
        hs_data.push_back(write_data);
        hs_idx.push_back(reg_index);
        issue_cnt[reg_index] = issue_cnt[reg_index] + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    hs_addr.delete();
    hs_data.delete();
    hs_idx.delete();
    foreach (issue_cnt[i]) issue_cnt[i] = 0;
    foreach (nack_left[i]) nack_left[i] = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (n < budget && !write_valid) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic wait_end(input int budget, output int n);
    n = 0;
    while (n < budget && !(done || fail)) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int n;
    int k;
    int vcnt;
    clear_log();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", write_valid, 0);
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_index", reg_index, 0);
    chk("rst_slav_addr", slav_addr, 7'h1A);
    chk("rst_rnw", read_not_write, 0);
    chk("rst_reg_addr", reg_addr, 8'h1E);
    chk("rst_wdata", write_data, 8'h00);

    // 1: clean run with an always-ACK master
    rst_n = 1'b1;
    wait_valid(1000, n);
    chk("t1_first_valid_cycle", n, 200);
    wait_end(2000, n);
    chk("t1_end_timeout", (n < 2000), 1);
    chk("t1_hs_count", hs_addr.size(), 11);
    for (int i = 0; i < 11; i++) begin
      if (i < hs_addr.size()) begin
        chk($sformatf("t1_addr%0d", i), hs_addr[i], exp_addr[i]);
        chk($sformatf("t1_data%0d", i), hs_data[i], exp_data[i]);
      end
    end
    chk("t1_done", done, 1);
    chk("t1_busy", busy, 0);
    chk("t1_fail", fail, 0);
    chk("t1_index", reg_index, 10);

    // 2: master stalls write_ready for 5 cycles at the first ISSUE
    clear_log();
    stall = 5;
    pulse_start();
    chk("t2_done_cleared", done, 0);
    chk("t2_busy", busy, 1);
    wait_valid(1000, n);
    chk("t2_first_valid_cycle", n, 200);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("t2_hold_valid%0d", i), write_valid, 1);
      chk($sformatf("t2_hold_addr%0d", i), reg_addr, 8'h1E);
      chk($sformatf("t2_no_hs%0d", i), hs_addr.size(), 0);
    end
    wait_end(2000, n);
    chk("t2_entry0_issues", issue_cnt[0], 1);
    chk("t2_hs_count", hs_addr.size(), 11);
    chk("t2_done", done, 1);

    // 3: entry 4 NACKed twice then ACKed
    clear_log();
    nack_left[4] = 2;
    pulse_start();
    wait_end(3000, n);
    chk("t3_entry4_issues", issue_cnt[4], 3);
    chk("t3_hs_count", hs_addr.size(), 13);
    chk("t3_done", done, 1);
    chk("t3_fail", fail, 0);

    // 4: entry 2 NACKed on every attempt
    clear_log();
    nack_left[2] = 100;
    pulse_start();
    wait_end(3000, n);
    chk("t4_entry2_issues", issue_cnt[2], 4);
    chk("t4_fail", fail, 1);
    chk("t4_done", done, 0);
    chk("t4_busy", busy, 0);
    chk("t4_index", reg_index, 2);
    vcnt = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (write_valid) vcnt++;
    end
    chk("t4_no_valid_after_fail", vcnt, 0);
    chk("t4_hs_count", hs_addr.size(), 6);

    // 5: restart from FAIL; a start pulse mid-run is ignored
    clear_log();
    pulse_start();
    chk("t5_fail_cleared", fail, 0);
    chk("t5_busy", busy, 1);
    k = 0;
    while (k < 1000 && !write_valid) begin
      @(posedge clk);
      #1;
      k++;
      if (k == 50) start = 1'b1;
      if (k == 51) start = 1'b0;
      if (k == 60) chk("t5_busy_after_midstart", busy, 1);
    end
    chk("t5_first_valid_cycle", k, 200);
    wait_end(2000, n);
    chk("t5_hs_count", hs_addr.size(), 11);
    chk("t5_done", done, 1);

    // 6: async reset while in ISSUE
    clear_log();
    stall = 1000;
    pulse_start();
    wait_valid(1000, n);
    @(posedge clk);
    #1;
    chk("t6_in_issue", write_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid_dropped", write_valid, 0);
    chk("t6_rst_busy", busy, 1);
    chk("t6_rst_index", reg_index, 0);
    stall = 0;
    @(posedge clk);
    #1;
    clear_log();
    rst_n = 1'b1;
    wait_valid(1000, n);
    chk("t6_first_valid_cycle", n, 200);
    wait_end(2000, n);
    chk("t6_hs_count", hs_addr.size(), 11);
    if (hs_idx.size() > 0) begin
      chk("t6_first_idx", hs_idx[0], 0);
      chk("t6_first_addr", hs_addr[0], 8'h1E);
    end
    chk("t6_done", done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
